mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the CPU datapath: register file, ALU, sign-extend and PC. It replaces single-cycle combinational control. It steps each instruction through fetch/decode/execute/memory/writeback over one shared, handshaked memory port. Halts on illegal opcode or memory timeout.

Parameters:
WAIT_MAX, 15, max consecutive cycles mem_req may stay high with mem_ready low before TRAP
CNT_WIDTH, 32, width of perf counters (optional feature only)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
instr  in  32  current instruction, from datapath IR register output
EQ  in  1  ALU equality flag (operands equal)
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe; valid with mem_req
AdrSrc  out  1  0 = PC, 1 = ALU result register as memory address
IRWrite  out  1  latch fetched word into IR
PCWrite  out  1  load PC from PC mux
PCsrc  out  1  0 = PC+4, 1 = PC+ImmOp
RegWrite  out  1  register file write enable
ResultSrc  out  2  0 = ALU result, 1 = memory data, 2 = PC+4
ALUsrc  out  1  0 = RD2, 1 = ImmOp
ALUctrl  out  alu_ctrl  ALU operation
ImmSrc  out  instr_format  immediate format for sign-extend
halted  out  1  sticky; set on entering TRAP

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, ALU_WB, TRAP.
- Outputs are Moore decodes of state plus instr fields. Every strobe not listed for a state is 0.
- Reset: state=IDLE, wait counter=0, halted=0. All outputs 0 while rst is high and in IDLE. IDLE->FETCH unconditionally on the next edge.
- FETCH: mem_req=1, AdrSrc=0. When mem_ready=1, the same cycle asserts IRWrite=1, PCWrite=1, PCsrc=0, and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: ImmSrc from opcode. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other -> TRAP
- EXEC_R: ALUsrc=0, ALUctrl decoded from funct3/funct7 -> ALU_WB.
- EXEC_I: ALUsrc=1, same decode with funct7 ignored except for shifts -> ALU_WB.
- ALU_WB: RegWrite=1, ResultSrc=0 -> FETCH.
- MEM_ADR: ALUsrc=1, ALUctrl=add, ImmSrc = I (load) or S (store) -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, AdrSrc=1. On mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, ResultSrc=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, AdrSrc=1. On mem_ready -> FETCH.
- BRANCH: ALUsrc=0, ALUctrl=sub, ImmSrc=B.
  - funct3=000 (BEQ) taken iff EQ; funct3=001 (BNE) taken iff !EQ.
  - Taken: PCWrite=1, PCsrc=1 (PC is the instruction address, already re-based by the datapath).
  - Other funct3 -> TRAP; otherwise -> FETCH.
- JAL: ImmSrc=J, RegWrite=1, ResultSrc=2, PCWrite=1, PCsrc=1 -> FETCH.
- Latency with zero-wait memory: R/I 4, LW 5, SW 4, branch 3, JAL 3 cycles.
- Wait counter:
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or any state change.
  - Reaching WAIT_MAX -> TRAP; mem_ready in that same cycle has priority (access completes).
- TRAP: all strobes 0, halted=1. Exit only via rst.
- rd=x0 writes still assert RegWrite; the register file discards them.
- Reset mid-access: mem_req drops asynchronously. No partial PC/IR/register update occurs.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt and instret_cnt [CNT_WIDTH-1:0], both reset to 0 asynchronously.
  - cycle_cnt increments every cycle while state is not IDLE or TRAP.
  - instret_cnt increments on each transition into FETCH from a completing state (ALU_WB, MEM_WB, MEM_WR, BRANCH, JAL).
  - Both wrap modulo 2^CNT_WIDTH and freeze in TRAP.
- Undefined: ports and logic absent.

Decomposition:
- types_pkg gains mc_state_t enum, opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL) and result_src_t (RES_ALU, RES_MEM, RES_PC4).
- Reuse existing alu_ctrl and instr_format.
- One sub-module: alu_decoder, combinational funct3/funct7/opcode -> alu_ctrl.

Test Plan:
- Reset, release, mem_ready tied 1, instr=add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 only in cycle 4; IRWrite/PCWrite only in cycle 1.
- lw x5,8(x0) with mem_ready low 3 cycles in MEM_RD -> mem_req=1, AdrSrc=1 held 4 cycles; RegWrite with ResultSrc=1 one cycle later; total 8 cycles.
- beq with EQ=1, then EQ=0 -> PCWrite=1, PCsrc=1 in BRANCH only when EQ=1; bne inverse.
- instr=0xFFFFFFFF -> TRAP after DECODE, halted=1, no strobes for 20 further cycles; rst restores IDLE with halted=0.
- mem_ready held 0 in FETCH -> TRAP after exactly WAIT_MAX=15 cycles. mem_ready=1 on cycle 15 instead -> DECODE.
- MC_PERF_CNT_EN: sequence add, sw, jal with zero-wait memory -> instret_cnt=3, cycle_cnt=11 at the third FETCH entry. Assert rst while in MEM_WR -> mem_req=0 immediately, counters 0.

Source files
------------

// File: rtl/types_pkg.sv
// types_pkg: shared control/datapath types for the multi-cycle CPU core.
//   alu_ctrl      - ALU operation select
//   instr_format  - immediate format for the sign-extend unit
//   result_src_t  - register-file write-back source select
//   mc_state_t    - multi-cycle control sequencer states
//   OP_*          - major opcodes recognised by the sequencer
//   imm_fmt()     - opcode -> immediate format
package types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_ctrl;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J} instr_format;

    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD,
        MEM_WB, MEM_WR, BRANCH, JAL, ALU_WB, TRAP
    } mc_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic instr_format imm_fmt(input logic [6:0] op);
        return op == OP_STORE ? FMT_S :
               op == OP_BRANCH ? FMT_B :
               op == OP_JAL ? FMT_J :
               (op == OP_I || op == OP_LOAD) ? FMT_I : FMT_R;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: funct3/funct7/opcode -> ALU operation.
//   opcode   in  major opcode (R-type enables SUB via funct7[5])
//   funct3   in  instruction funct3
//   funct7_5 in  instruction bit 30 (SUB / SRA select)
//   ctrl     out ALU operation
module alu_decoder
    import types_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl    ctrl
);

    // Bit 30 selects SUB only for register ops; for ADDI it is immediate data.
    // Shifts honour it in both forms (SRA vs SRL).
    always_comb begin
        ctrl = ALU_ADD;
        case (funct3)
            3'b000: ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: ctrl = ALU_SLL;
            3'b010: ctrl = ALU_SLT;
            3'b011: ctrl = ALU_SLTU;
            3'b100: ctrl = ALU_XOR;
            3'b101: ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: ctrl = ALU_OR;
            3'b111: ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer (fetch/decode/execute/memory/writeback).
//   clk, rst (async, active-high)
//   instr, EQ, mem_ready                      - inputs from IR, ALU flag, memory
//   mem_req, mem_we, AdrSrc                   - shared memory port control
//   IRWrite, PCWrite, PCsrc                   - IR / PC update
//   RegWrite, ResultSrc, ALUsrc, ALUctrl, ImmSrc - datapath control
//   halted                                    - set while in TRAP (illegal op / memory timeout)
//   cycle_cnt, instret_cnt                    - perf counters, only with MC_PERF_CNT_EN
module mc_control_fsm
    import types_pkg::*;
#(
    parameter int WAIT_MAX = 15
`ifdef MC_PERF_CNT_EN
    , parameter int CNT_WIDTH = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCsrc,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUsrc,
    output alu_ctrl     ALUctrl,
    output instr_format ImmSrc,
    output logic        halted
`ifdef MC_PERF_CNT_EN
    , output logic [CNT_WIDTH-1:0] cycle_cnt
    , output logic [CNT_WIDTH-1:0] instret_cnt
`endif
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    mc_state_t   state, next;
    logic [WW-1:0] wait_cnt;
    alu_ctrl     dec_ctrl;
    logic        taken;
    logic        unused_bits;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] funct3 = instr[14:12];

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7_5(instr[30]),
        .ctrl    (dec_ctrl)
    );

    assign taken = (funct3 == 3'b000 && EQ) || (funct3 == 3'b001 && !EQ);

    always_comb begin
        next      = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALU;
        ALUsrc    = 1'b0;
        ALUctrl   = ALU_ADD;
        ImmSrc    = FMT_R;
        halted    = 1'b0;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ImmSrc = imm_fmt(opcode);
                next   = opcode == OP_R ? EXEC_R :
                         opcode == OP_I ? EXEC_I :
                         (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADR :
                         opcode == OP_BRANCH ? BRANCH :
                         opcode == OP_JAL ? JAL : TRAP;
            end
            EXEC_R: begin
                ALUctrl = dec_ctrl;
                next    = ALU_WB;
            end
            EXEC_I: begin
                ALUsrc  = 1'b1;
                ALUctrl = dec_ctrl;
                ImmSrc  = FMT_I;
                next    = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            MEM_ADR: begin
                ALUsrc = 1'b1;
                ImmSrc = opcode == OP_STORE ? FMT_S : FMT_I;
                next   = opcode == OP_STORE ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                next    = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
                next      = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                AdrSrc  = 1'b1;
                next    = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                ALUctrl = ALU_SUB;
                ImmSrc  = FMT_B;
                PCWrite = taken;
                PCsrc   = taken;
                next    = funct3[2:1] == 2'b00 ? FETCH : TRAP;
            end
            JAL: begin
                ImmSrc    = FMT_J;
                RegWrite  = 1'b1;
                ResultSrc = RES_PC4;
                PCWrite   = 1'b1;
                PCsrc     = 1'b1;
                next      = FETCH;
            end
            TRAP: halted = 1'b1;
            default: next = TRAP;
        endcase
        // A stalled access that has used up its budget traps; a completing
        // access (mem_ready) in the same cycle is not stalled, so it wins.
        if (mem_req && !mem_ready && wait_cnt == WW'(WAIT_MAX - 1))
            next = TRAP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next;
            wait_cnt <= (mem_req && !mem_ready && next == state) ? wait_cnt + WW'(1) : '0;
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != IDLE && state != TRAP)
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (next == FETCH && state inside {ALU_WB, MEM_WB, MEM_WR, BRANCH, JAL})
                instret_cnt <= instret_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
